// File: rtl/instruction_fetch_controller.sv
// Fetches one 16-bit instruction as two byte reads (low byte, then high byte), advancing the PC.
// Latency: Start edge to Done pulse is 3 cycles with zero-wait memory, plus one cycle per wait state.
// Backpressure: MemReq/MemAddr are held while MemAck is low, with no limit on wait cycles; Abort cancels the fetch.
//
// Ports:
//   Clock, Reset             - single clock; asynchronous active-high reset
//   Start, Abort             - request one instruction fetch / cancel the fetch in progress
//   PCLoad, PCIn             - load the PC (IDLE only)
//   MemReq, MemAddr          - byte read request and address (address is always the PC)
//   MemAck, MemData          - read data valid and the returned byte
//   IR_I, IR_Write, IR_LH    - byte, write enable and half select (1 = bits 15:8) for the instruction register
//   PCOut, Busy, Done        - current PC, fetch in progress, one-cycle completion pulse
module instruction_fetch_controller (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Abort,
    input  logic        PCLoad,
    input  logic [15:0] PCIn,
    input  logic        MemAck,
    input  logic [7:0]  MemData,
    output logic        MemReq,
    output logic [15:0] MemAddr,
    output logic [7:0]  IR_I,
    output logic        IR_Write,
    output logic        IR_LH,
    output logic [15:0] PCOut,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] pc_nxt;
    logic [15:0] fetch_base;
    logic [15:0] fetch_base_nxt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            pc         <= 16'h0000;
            fetch_base <= 16'h0000;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            fetch_base <= fetch_base_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        fetch_base_nxt = fetch_base;
        MemReq         = 1'b0;
        IR_I           = 8'h00;
        IR_Write       = 1'b0;
        IR_LH          = 1'b0;
        Busy           = 1'b0;
        Done           = 1'b0;

        case (state)
            IDLE: begin
                // PCLoad wins over Start; a Start seen alongside PCLoad is dropped.
                if (PCLoad) begin
                    pc_nxt = PCIn;
                end else if (Start) begin
                    fetch_base_nxt = pc;
                    state_nxt      = FETCH_LO;
                end
            end

            FETCH_LO, FETCH_HI: begin
                MemReq = 1'b1;
                Busy   = 1'b1;
                IR_I   = MemData;
                IR_LH  = (state == FETCH_HI);
                // Abort outranks MemAck: the byte is discarded and the PC rewinds
                // to where this fetch began, so a retry refetches the same word.
                if (Abort) begin
                    pc_nxt    = fetch_base;
                    state_nxt = IDLE;
                end else if (MemAck) begin
                    IR_Write  = 1'b1;
                    pc_nxt    = pc + 16'd1;
                    state_nxt = (state == FETCH_HI) ? DONE : FETCH_HI;
                end
            end

            DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign MemAddr = pc;
    assign PCOut   = pc;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench for instruction_fetch_controller: directed scenarios plus randomized traffic
// checked against a transaction-level reference model (PC, fetch base, bytes fetched, done flag).
// Inputs change on the falling edge; outputs are sampled just after, well away from the rising edge.
module tb_instruction_fetch_controller;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Abort;
    logic        PCLoad;
    logic [15:0] PCIn;
    logic        MemAck;
    logic [7:0]  MemData;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic [7:0]  IR_I;
    logic        IR_Write;
    logic        IR_LH;
    logic [15:0] PCOut;
    logic        Busy;
    logic        Done;

    int vectors    = 0;
    int miscompares = 0;

    instruction_fetch_controller dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
        .PCLoad(PCLoad), .PCIn(PCIn), .MemAck(MemAck), .MemData(MemData),
        .MemReq(MemReq), .MemAddr(MemAddr), .IR_I(IR_I), .IR_Write(IR_Write),
        .IR_LH(IR_LH), .PCOut(PCOut), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // Reference model: a fetch is "in flight" until two bytes are acknowledged.
    logic [15:0] m_pc;
    logic [15:0] m_base;
    bit          m_active;
    int          m_bytes;
    bit          m_done;

    logic [36:0] dut_vec;
    assign dut_vec = {MemReq, MemAddr, IR_Write, IR_LH, PCOut, Busy, Done};

    task automatic model_reset();
        m_pc = 16'h0000; m_base = 16'h0000; m_active = 0; m_bytes = 0; m_done = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_update();
        if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (Abort) begin
                m_pc = m_base;
                m_active = 0;
            end else if (MemAck) begin
                m_pc = m_pc + 16'd1;
                m_bytes++;
                if (m_bytes == 2) begin
                    m_active = 0;
                    m_done = 1;
                end
            end
        end else if (PCLoad) begin
            m_pc = PCIn;
        end else if (Start) begin
            m_base = m_pc;
            m_active = 1;
            m_bytes = 0;
        end
    endtask

    function automatic logic [36:0] exp_vec();
        logic wr;
        wr = m_active && MemAck && !Abort;
        return {m_active, m_pc, wr, (m_active && m_bytes == 1), m_pc, (m_active || m_done), m_done};
    endfunction

    task automatic tick();
        if (Reset) model_reset(); else model_update();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic clear_inputs();
        Start = 0; Abort = 0; PCLoad = 0; PCIn = 16'h0000; MemAck = 0; MemData = 8'h00;
    endtask

    task automatic load_pc(input logic [15:0] v);
        PCLoad = 1; PCIn = v;
        tick();
        PCLoad = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 1;
        model_reset();
        #1;
        vectors++;
        if (dut_vec !== 37'h0) begin
            miscompares++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, 37'h0);
        end
        @(negedge Clock);
        Reset = 0;
        #1;
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++; $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_zero_wait();
        logic [15:0] ir;
        ir = 16'h0000;
        load_pc(16'h0010);
        Start = 1;
        tick();
        Start = 0;
        MemAck = 1; MemData = 8'h34;
        #1;
        vectors++;
        if ({IR_Write, IR_LH, IR_I, MemAddr} !== {1'b1, 1'b0, 8'h34, 16'h0010}) begin
            miscompares++; $display("FAIL zw_lo_byte: got %b %b %h %h expected 1 0 34 0010", IR_Write, IR_LH, IR_I, MemAddr);
        end
        if (IR_Write) ir[7:0] = IR_I;
        tick();
        MemData = 8'h12;
        #1;
        vectors++;
        if ({IR_Write, IR_LH, IR_I, MemAddr} !== {1'b1, 1'b1, 8'h12, 16'h0011}) begin
            miscompares++; $display("FAIL zw_hi_byte: got %b %b %h %h expected 1 1 12 0011", IR_Write, IR_LH, IR_I, MemAddr);
        end
        if (IR_Write) ir[15:8] = IR_I;
        tick();
        MemAck = 0;
        #1;
        vectors++;
        if ({Done, Busy, PCOut} !== {1'b1, 1'b1, 16'h0012}) begin
            miscompares++; $display("FAIL zw_done_cycle3: got done=%b busy=%b pc=%h expected 1 1 0012", Done, Busy, PCOut);
        end
        vectors++;
        if (ir !== 16'h1234) begin
            miscompares++; $display("FAIL zw_ir_word: got %h expected 1234", ir);
        end
        tick();
        #1;
        vectors++;
        if (dut_vec !== exp_vec() || Done !== 1'b0 || Busy !== 1'b0) begin
            miscompares++; $display("FAIL zw_back_idle: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_wait_states();
        int edges = 1;
        int w = 0;
        int nb = 0;
        int done_at = -1;
        load_pc(16'h0010);
        Start = 1;
        tick();
        Start = 0;
        while (edges < 20) begin
            MemAck = (w == 2);
            MemData = 8'h50 + 8'(nb);
            #1;
            if (Done) begin
                done_at = edges;
                break;
            end
            vectors++;
            if (MemAddr !== 16'h0010 + 16'(nb) || IR_Write !== (w == 2) || MemReq !== 1'b1) begin
                miscompares++; $display("FAIL ws_hold: edge %0d got addr=%h wr=%b req=%b expected addr=%h wr=%b req=1",
                                        edges, MemAddr, IR_Write, MemReq, 16'h0010 + 16'(nb), (w == 2));
            end
            tick();
            edges++;
            if (w == 2) begin w = 0; nb++; end else w++;
        end
        MemAck = 0;
        vectors++;
        if (done_at !== 7) begin
            miscompares++; $display("FAIL ws_done_cycle: got %0d expected 7", done_at);
        end
        tick();
    endtask

    task automatic test_wrap();
        load_pc(16'hFFFF);
        Start = 1;
        tick();
        Start = 0;
        MemAck = 1;
        #1;
        vectors++;
        if (MemAddr !== 16'hFFFF) begin
            miscompares++; $display("FAIL wrap_addr_lo: got %h expected FFFF", MemAddr);
        end
        tick();
        #1;
        vectors++;
        if (MemAddr !== 16'h0000) begin
            miscompares++; $display("FAIL wrap_addr_hi: got %h expected 0000", MemAddr);
        end
        tick();
        MemAck = 0;
        #1;
        vectors++;
        if (PCOut !== 16'h0001 || Done !== 1'b1) begin
            miscompares++; $display("FAIL wrap_final_pc: got pc=%h done=%b expected 0001 1", PCOut, Done);
        end
        tick();
    endtask

    task automatic test_abort_hi();
        int dones = 0;
        load_pc(16'h0020);
        Start = 1;
        tick();
        Start = 0;
        MemAck = 1; MemData = 8'hAA;
        tick();
        Abort = 1; MemData = 8'hBB;
        #1;
        vectors++;
        if (IR_Write !== 1'b0 || IR_LH !== 1'b1) begin
            miscompares++; $display("FAIL abort_no_write: got wr=%b lh=%b expected 0 1", IR_Write, IR_LH);
        end
        tick();
        Abort = 0; MemAck = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (Done) dones++;
            if (i == 0) begin
                vectors++;
                if ({PCOut, Busy, MemReq} !== {16'h0020, 1'b0, 1'b0}) begin
                    miscompares++; $display("FAIL abort_restore: got pc=%h busy=%b req=%b expected 0020 0 0", PCOut, Busy, MemReq);
                end
            end
            tick();
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
        end
    endtask

    task automatic test_pcload_start();
        Start = 1; PCLoad = 1; PCIn = 16'h0100;
        tick();
        Start = 0; PCLoad = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if ({PCOut, MemReq, Busy} !== {16'h0100, 1'b0, 1'b0}) begin
                miscompares++; $display("FAIL pcload_priority: cycle %0d got pc=%h req=%b busy=%b expected 0100 0 0", i, PCOut, MemReq, Busy);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        int dones = 0;
        load_pc(16'h0050);
        Start = 1;
        tick();
        Start = 0;
        #1;
        vectors++;
        if ({MemReq, PCOut} !== {1'b1, 16'h0050}) begin
            miscompares++; $display("FAIL ar_in_fetch: got req=%b pc=%h expected 1 0050", MemReq, PCOut);
        end
        #1;
        Reset = 1;
        model_reset();
        #1;
        vectors++;
        if ({MemReq, Busy, PCOut, IR_Write, Done} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL ar_immediate: got req=%b busy=%b pc=%h wr=%b done=%b expected 0 0 0000 0 0",
                                    MemReq, Busy, PCOut, IR_Write, Done);
        end
        @(negedge Clock);
        Reset = 0;
        MemAck = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (Done || IR_Write) dones++;
            tick();
        end
        MemAck = 0;
        vectors++;
        if (dones !== 0) begin
            miscompares++; $display("FAIL ar_no_done: got %0d done/write cycles expected 0", dones);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            Reset   = ($urandom_range(0, 60) == 0);
            Start   = ($urandom_range(0, 2) == 0);
            PCLoad  = ($urandom_range(0, 5) == 0);
            PCIn    = 16'($urandom);
            MemAck  = ($urandom_range(0, 1) == 0);
            MemData = 8'($urandom);
            Abort   = ($urandom_range(0, 9) == 0);
            if (Reset) model_reset();
            #1;
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++; $display("FAIL rand_outputs: step %0d got %h expected %h", i, dut_vec, exp_vec());
            end
            if (IR_Write) begin
                vectors++;
                if (IR_I !== MemData) begin
                    miscompares++; $display("FAIL rand_ir_data: step %0d got %h expected %h", i, IR_I, MemData);
                end
            end
            tick();
            Reset = 0;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_wrap();
        test_abort_hi();
        test_pcload_start();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
